// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the 8-bit CPU family.
// Holds the instruction-ROM fetch address and supports stall, absolute jump,
// and subroutine call/return through an internal return-address stack.
// Compile-time option: PC_SEQ_STACK_EN builds the return-address stack. When it
// is undefined, call behaves as jump, ret behaves as sequential, and the stack
// status outputs are tied to their empty values.
module pc_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STEP        = 2,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             n_reset,
    input  logic                             advance,
    input  logic                             jump,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                jump_addr,
    input  logic                             clr_err,
    output logic [ADDR_W-1:0]                pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             overflow,
    output logic                             underflow,
    output logic                             cmd_err
);

    localparam int                LVL_W  = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    logic [ADDR_W-1:0] r_pc;
    logic              r_cmd_err;

    logic [ADDR_W-1:0] w_next_seq;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [1:0]        w_cmd_cnt;
    logic              w_cmd_err_set;

    // Sequential successor (wraps silently) and multi-command detection
    always_comb begin
        w_next_seq    = r_pc + STEP_V;
        w_cmd_cnt     = {1'b0, jump} + {1'b0, call} + {1'b0, ret};
        w_cmd_err_set = advance && (w_cmd_cnt > 2'd1);
    end

`ifdef PC_SEQ_STACK_EN
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level_dec;
    logic [PTR_W-1:0]  w_push_idx;
    logic [PTR_W-1:0]  w_pop_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;

    // Stack occupancy and read/write pointers derived from the level count
    always_comb begin
        w_full      = (r_level == LVL_W'(STACK_DEPTH));
        w_empty     = (r_level == '0);
        w_level_dec = r_level - LVL_W'(1);
        w_push_idx  = PTR_W'(r_level);
        w_pop_idx   = PTR_W'(w_level_dec);
    end

    // Command decode with priority call > ret > jump > sequential
    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (advance) begin
            if (call) begin
                if (w_full) begin
                    w_pc_nxt  = w_next_seq;
                    w_ovf_set = 1'b1;
                end else begin
                    w_pc_nxt = jump_addr;
                    w_push   = 1'b1;
                end
            end else if (ret) begin
                if (w_empty) begin
                    w_pc_nxt  = w_next_seq;
                    w_unf_set = 1'b1;
                end else begin
                    w_pc_nxt = r_stack[w_pop_idx];
                    w_pop    = 1'b1;
                end
            end else if (jump) begin
                w_pc_nxt = jump_addr;
            end else begin
                w_pc_nxt = w_next_seq;
            end
        end
    end

    // Return-address storage; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_next_seq;
        end
    end

    // Stack level and sticky stack error flags
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop) begin
                r_level <= w_level_dec;
            end
            r_overflow  <= w_ovf_set || (r_overflow && !clr_err);
            r_underflow <= w_unf_set || (r_underflow && !clr_err);
        end
    end

    // Stack status outputs
    always_comb begin
        stack_level = r_level;
        stack_full  = w_full;
        stack_empty = w_empty;
        overflow    = r_overflow;
        underflow   = r_underflow;
    end
`else
    // Command decode without a stack: call acts as jump, ret as sequential
    always_comb begin
        w_pc_nxt = r_pc;
        if (advance) begin
            if (call) begin
                w_pc_nxt = jump_addr;
            end else if (ret) begin
                w_pc_nxt = w_next_seq;
            end else if (jump) begin
                w_pc_nxt = jump_addr;
            end else begin
                w_pc_nxt = w_next_seq;
            end
        end
    end

    // Stack status outputs tied to their empty values
    always_comb begin
        stack_level = '0;
        stack_full  = 1'b0;
        stack_empty = 1'b1;
        overflow    = 1'b0;
        underflow   = 1'b0;
    end
`endif

    // Program counter and sticky command-collision flag
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pc      <= RESET_ADDR;
            r_cmd_err <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_cmd_err <= w_cmd_err_set || (r_cmd_err && !clr_err);
        end
    end

    // Registered outputs
    always_comb begin
        pc_out  = r_pc;
        cmd_err = r_cmd_err;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the 8-bit CPU family, replacing the fixed +2 PC. It holds the fetch address presented to instruction ROM and supports stall, absolute jump, and subroutine call/return through an internal return-address stack. It has configurable address width, step and stack depth, and reports stack status and sticky error flags. It sits between the controller (command inputs) and the ROM address bus (`pc_out`).

## Interface
Parameters:
- `ADDR_W`, default 8: PC and jump-address width.
- `STEP`, default 2: increment per advance, in bytes; legal range 1 to 2^ADDR_W−1.
- `STACK_DEPTH`, default 4: return-address stack entries; must be ≥1.
- `RESET_ADDR`, default 0: PC value after reset.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `n_reset` in 1: asynchronous, active-low reset.
- `advance` in 1: PC update enable; 0 = stall, all state held.
- `jump` in 1: absolute branch to `jump_addr`.
- `call` in 1: push return address, branch to `jump_addr`.
- `ret` in 1: pop stack into PC.
- `jump_addr` in ADDR_W: branch/call target.
- `clr_err` in 1: clears sticky error flags.
- `pc_out` out ADDR_W: current fetch address (registered).
- `stack_level` out $clog2(STACK_DEPTH+1): occupied entries.
- `stack_full` out 1: `stack_level == STACK_DEPTH`.
- `stack_empty` out 1: `stack_level == 0`.
- `overflow` out 1: sticky; call attempted while full.
- `underflow` out 1: sticky; ret attempted while empty.
- `cmd_err` out 1: sticky; more than one of `jump`/`call`/`ret` asserted with `advance`.

## Operation
- Reset values: `pc_out`=RESET_ADDR, `stack_level`=0, `stack_empty`=1, `stack_full`=0, `overflow`=`underflow`=`cmd_err`=0. Stack contents are don't-care.
- `next_seq = (pc_out + STEP) mod 2^ADDR_W`. Wrap-around is silent, e.g. 8'hFE+2 → 8'h00.
- Commands are evaluated only when `advance`=1. Priority: `call` > `ret` > `jump` > sequential.
- call, not full: stack[level] ← next_seq, level+1, PC ← jump_addr.
- call, full: no push, PC ← next_seq, `overflow` set.
- ret, not empty: PC ← stack[level−1], level−1.
- ret, empty: PC ← next_seq, `underflow` set.
- jump: PC ← jump_addr; stack untouched.
- none: PC ← next_seq.
- Two or more commands asserted: `cmd_err` set, and only the highest-priority command executes.
- `advance`=0: PC, stack and flags hold. Commands are ignored and raise no errors.
- Sticky flags: set conditions OR-ed in each cycle. When `clr_err`=1, flags clear at the next posedge, but a set condition in the same cycle wins (flag reads 1).
- `clr_err` is honoured regardless of `advance`.

## Timing
- Single-cycle: commands are sampled at posedge and new `pc_out` is visible after that edge. There is no combinational path from inputs to any output.
- Return address pushed by a call at cycle N is returned by a ret at cycle N+k, for any k ≥1; back-to-back call→ret is legal.
- `n_reset` assertion forces reset values immediately, independent of `clk`. Deassertion is synchronised externally; the first update occurs at the first posedge with `n_reset`=1.
- Reset mid-subroutine discards all stack entries.

## Configuration
- `PC_SEQ_STACK_EN` defined: return-address stack, `stack_*` outputs, and `overflow`/`underflow` behave as above.
- `PC_SEQ_STACK_EN` undefined: no stack storage is built.
  - `call` acts as `jump`; `ret` acts as sequential.
  - `stack_level`=0, `stack_empty`=1, `stack_full`=0, `overflow`=`underflow`=0 constantly.
  - `cmd_err` and priority are still active.

## Test plan
- Reset/sequential (defaults): release reset, `advance`=1 for 4 cycles → `pc_out` 0,2,4,6,8. Hold `advance`=0 for 2 cycles → stays 8.
- Wrap: jump to 8'hFC, then 3 sequential advances → FE, 00, 02. Flags stay 0.
- Nested call/ret, DEPTH=4:
  - Calls from PCs 10,20,30 to targets 20,30,40.
  - Three rets → `pc_out` 32, 22, 12; `stack_level` goes 3 then back to 0.
- Overflow/underflow:
  - 5 calls at DEPTH=4 → 5th gives PC=prev+2, `overflow`=1, level=4.
  - 5 rets → 5th gives PC=prev+2, `underflow`=1.
  - `clr_err` pulse → both 0.
- Collision: `call`=`jump`=1, `jump_addr`=8'h40 at PC 6 → PC=40, stack top=08, `cmd_err`=1.
- Async reset mid-run: assert `n_reset` between edges with level=2 → `pc_out`=RESET_ADDR and level=0 before the next posedge. Rebuild with `PC_SEQ_STACK_EN` undefined: call to 8'h40 → PC=40, level stays 0.
